ldlt_stream_engine: RTL and testbench
=====================================

LDLT_STREAM_ENGINE -- requirements
Module: ldlt_stream_engine

Interface
REQ-001 SHALL provide parameters: W, default 64, data word width; N_MAX, default 16, max matrix order; CONST_VAL, default 64'h3FF0000000000000 (1.0), mode-0 result word, truncated to W.
REQ-002 SHALL have ports: clock  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: start in 1 job request; abort in 1 cancel job; rows in 16 matrix rows; cols in 16 matrix cols; mode in 2 result select.
REQ-004 SHALL have ports: busy out 1 job active; done out 1 job-complete pulse; err out 1 job error flag.
REQ-005 SHALL have ports: data_in in W A then b stream; data_in_valid in 1; data_in_ready out 1.
REQ-006 SHALL have ports: data_out out W x stream; data_out_valid out 1; data_out_ready in 1.

Function
REQ-007 SHALL implement states IDLE, CHECK, RECV, COMPUTE, SEND, FIN; busy = (state != IDLE).
REQ-008 SHALL accept start only in IDLE, registering rows, cols, mode and clearing err, then entering CHECK; start while busy SHALL be ignored.
REQ-009 CHECK SHALL last one cycle: if rows != cols, rows == 0, rows > N_MAX, or mode == 3, set err=1 and go to FIN with no data consumed; else go to RECV.
REQ-010 data_in_ready SHALL be 1 exactly when state == RECV; a word transfers on a cycle with data_in_valid && data_in_ready.
REQ-011 RECV SHALL consume rows*rows A words, row-major, then rows b words, tracked by row/col counters (no multiplier required).
REQ-012 A word at (r,c) with r == c SHALL be stored to diag[r]; other A words SHALL be discarded; b word i SHALL be stored to bvec[i].
REQ-013 On the transfer of the final b word the FSM SHALL enter COMPUTE, lasting exactly one cycle, then SEND with index 0.
REQ-014 Result word i SHALL be: mode 0 -> CONST_VAL; mode 1 -> bvec[i]; mode 2 -> diag[i].
REQ-015 data_out and data_out_valid SHALL be registered; data_out_valid SHALL rise in the first SEND cycle (two cycles after the final input transfer).
REQ-016 While data_out_valid && !data_out_ready, data_out SHALL hold stable; after each transfer the next word SHALL appear on the following cycle with valid kept high.
REQ-017 Exactly rows words SHALL be emitted; after the last transfer data_out_valid SHALL drop next cycle and the FSM SHALL enter FIN.
REQ-018 FIN SHALL assert done for exactly one cycle, then return to IDLE; err SHALL hold its value until the next accepted start.
REQ-019 abort in any non-IDLE state SHALL force IDLE next cycle, drop data_out_valid and data_in_ready, produce no done pulse and leave err unchanged; abort in IDLE SHALL have no effect.
REQ-020 abort SHALL take priority over every other transition in the same cycle.
REQ-021 Storage SHALL not be cleared between jobs; only entries written by the current job SHALL be read.

Reset
REQ-022 reset SHALL force IDLE and drive busy=0, done=0, err=0, data_in_ready=0, data_out_valid=0, data_out=0, and clear all counters.
REQ-023 reset asserted mid-job SHALL abandon the job with no done pulse; the first start after reset release SHALL be accepted normally.

Verification
REQ-024 rows=cols=4, mode 0, 20 words streamed -> 4 outputs of CONST_VAL, first valid 2 cycles after last input, done one cycle after 4th transfer, err=0.
REQ-025 rows=cols=3, mode 2, A[i][j]=10*i+j -> outputs 0, 11, 22; mode 1 with b=7,8,9 -> outputs 7, 8, 9.
REQ-026 rows=3, cols=4 (and separately rows=N_MAX+1, mode=3) -> data_in_ready never high, done pulse with err=1 within 3 cycles of start.
REQ-027 data_out_ready toggled randomly in mode 1 -> every word held stable while stalled, exactly rows transfers, order preserved.
REQ-028 abort after 5 of 20 input words, then new rows=cols=2 job -> no done for first job, second job completes with correct 2 outputs.
REQ-029 start asserted during SEND and reset asserted mid-RECV -> start ignored, reset returns all outputs to REQ-022 values next cycle.

Source files
------------

// File: rtl/ldlt_stream_engine.sv
// Streaming LDL^T front-end: checks the job shape, captures the diagonal of A and the b vector,
// then streams back one of three per-row result words under valid/ready flow control.
module ldlt_stream_engine #(
    parameter int          W         = 64,
    parameter int          N_MAX     = 16,
    parameter logic [63:0] CONST_VAL = 64'h3FF0000000000000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [15:0]  rows,
    input  logic [15:0]  cols,
    input  logic [1:0]   mode,
    output logic         busy,
    output logic         done,
    output logic         err,
    input  logic [W-1:0] data_in,
    input  logic         data_in_valid,
    output logic         data_in_ready,
    output logic [W-1:0] data_out,
    output logic         data_out_valid,
    input  logic         data_out_ready
);
    // state   | meaning
    // IDLE    | waiting for start
    // CHECK   | one-cycle validation of the registered job shape
    // RECV    | consuming A row-major, then b
    // COMPUTE | one cycle, preloads result word 0
    // SEND    | streaming rows result words
    // FIN     | one-cycle done pulse
    localparam int IW = (N_MAX > 1) ? $clog2(N_MAX) : 1;
    localparam logic [W-1:0] CONST_W = CONST_VAL[W-1:0];

    typedef enum logic [2:0] {IDLE, CHECK, RECV, COMPUTE, SEND, FIN} state_t;

    state_t       state_q, state_d;
    logic [15:0]  rows_q, rows_d, cols_q, cols_d;
    logic [1:0]   mode_q, mode_d;
    logic         err_q, err_d;
    logic [15:0]  row_q, row_d, col_q, col_d;
    logic         bphase_q, bphase_d;
    logic [W-1:0] dout_q, dout_d;
    logic         dval_q, dval_d;
    logic [W-1:0] diag_q [N_MAX];
    logic [W-1:0] bvec_q [N_MAX];
    logic         diag_we, bvec_we;
    logic         in_fire, out_fire;
    logic [15:0]  last_idx, rd_idx;
    logic [W-1:0] rd_word;

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == FIN);
    assign err            = err_q;
    assign data_in_ready  = (state_q == RECV);
    assign data_out       = dout_q;
    assign data_out_valid = dval_q;
    assign in_fire        = data_in_valid && data_in_ready;
    assign out_fire       = dval_q && data_out_ready;
    assign last_idx       = rows_q - 16'd1;

    // Read port: word 0 is fetched in COMPUTE, word i+1 on each SEND transfer.
    always_comb begin
        rd_idx  = (state_q == SEND) ? col_q + 16'd1 : 16'd0;
        rd_word = '0;
        case (mode_q)
            2'd0:    rd_word = CONST_W;
            2'd1:    rd_word = bvec_q[rd_idx[IW-1:0]];
            2'd2:    rd_word = diag_q[rd_idx[IW-1:0]];
            default: rd_word = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        rows_d   = rows_q;
        cols_d   = cols_q;
        mode_d   = mode_q;
        err_d    = err_q;
        row_d    = row_q;
        col_d    = col_q;
        bphase_d = bphase_q;
        dout_d   = dout_q;
        dval_d   = dval_q;
        diag_we  = 1'b0;
        bvec_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rows_d  = rows;
                    cols_d  = cols;
                    mode_d  = mode;
                    err_d   = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (rows_q != cols_q || rows_q == 16'd0 || rows_q > 16'(N_MAX) || mode_q == 2'd3) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    row_d    = '0;
                    col_d    = '0;
                    bphase_d = 1'b0;
                    state_d  = RECV;
                end
            end
            RECV: begin
                if (in_fire) begin
                    if (!bphase_q) begin
                        diag_we = (row_q == col_q);
                        if (col_q == last_idx) begin
                            col_d = '0;
                            if (row_q == last_idx) bphase_d = 1'b1;
                            else                   row_d    = row_q + 16'd1;
                        end else begin
                            col_d = col_q + 16'd1;
                        end
                    end else begin
                        bvec_we = 1'b1;
                        if (col_q == last_idx) begin
                            col_d   = '0;
                            state_d = COMPUTE;
                        end else begin
                            col_d = col_q + 16'd1;
                        end
                    end
                end
            end
            COMPUTE: begin
                dout_d  = rd_word;
                dval_d  = 1'b1;
                col_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                if (out_fire) begin
                    if (col_q == last_idx) begin
                        dval_d  = 1'b0;
                        state_d = FIN;
                    end else begin
                        col_d  = col_q + 16'd1;
                        dout_d = rd_word;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            dval_d  = 1'b0;
            diag_we = 1'b0;
            bvec_we = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            rows_q   <= '0;
            cols_q   <= '0;
            mode_q   <= '0;
            err_q    <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            bphase_q <= 1'b0;
            dout_q   <= '0;
            dval_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rows_q   <= rows_d;
            cols_q   <= cols_d;
            mode_q   <= mode_d;
            err_q    <= err_d;
            row_q    <= row_d;
            col_q    <= col_d;
            bphase_q <= bphase_d;
            dout_q   <= dout_d;
            dval_q   <= dval_d;
        end
    end

    // Operand storage is never cleared; a job only reads entries it has written.
    always_ff @(posedge clock) begin
        if (diag_we) diag_q[row_q[IW-1:0]] <= data_in;
        if (bvec_we) bvec_q[col_q[IW-1:0]] <= data_in;
    end
endmodule

// File: tb/tb_ldlt_stream_engine.sv
// Randomized bench for ldlt_stream_engine: a high-level job model derives the expected result
// stream from the matrix, b vector and mode, and each scenario task checks its own outcomes.
module tb_ldlt_stream_engine;
    localparam int W  = 64;
    localparam int NM = 16;
    localparam logic [W-1:0] ONE = 64'h3FF0000000000000;

    logic         clock = 1'b0;
    logic         reset, start, abort;
    logic [15:0]  rows, cols;
    logic [1:0]   mode;
    logic         busy, done, err;
    logic [W-1:0] data_in;
    logic         data_in_valid, data_in_ready;
    logic [W-1:0] data_out;
    logic         data_out_valid, data_out_ready;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] a_m [NM][NM];
    logic [W-1:0] b_v [NM];

    ldlt_stream_engine #(.W(W), .N_MAX(NM), .CONST_VAL(ONE)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .rows(rows), .cols(cols), .mode(mode),
        .busy(busy), .done(done), .err(err),
        .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic fill(input bit directed);
        for (int i = 0; i < NM; i++) begin
            for (int j = 0; j < NM; j++)
                a_m[i][j] = directed ? W'(10 * i + j) : {$urandom, $urandom};
            b_v[i] = directed ? W'(7 + i) : {$urandom, $urandom};
        end
    endtask

    // Push n words with valid held high; returns how many actually transferred.
    task automatic feed(input int n, output int sent);
        int cyc;
        bit fire;
        sent = 0;
        cyc  = 0;
        while (sent < n && cyc < 200) begin
            data_in_valid = 1'b1;
            data_in       = a_m[sent / 4][sent % 4];
            fire = data_in_ready;
            step();
            if (fire) sent++;
            cyc++;
        end
        data_in_valid = 1'b0;
    endtask

    task automatic run_job(input int n, input logic [1:0] m, input bit in_gaps, input bit out_stall,
                           input bit start_in_send, input string tag);
        logic [W-1:0] words[$];
        logic [W-1:0] expq[$];
        int  k, cyc, cnt;
        bit  fire;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) words.push_back(a_m[r][c]);
        for (int i = 0; i < n; i++) words.push_back(b_v[i]);
        for (int i = 0; i < n; i++)
            expq.push_back(m == 2'd0 ? ONE : (m == 2'd1 ? b_v[i] : a_m[i][i]));

        rows = 16'(n); cols = 16'(n); mode = m; start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || err !== 1'b0)
            $display("FAIL %s start_accept: busy=%b err=%b want busy=1 err=0", tag, busy, err);
        if (busy !== 1'b1 || err !== 1'b0) bad++;

        k = 0; cyc = 0;
        while (k < words.size() && cyc < 3000) begin
            data_in_valid = in_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            data_in       = words[k];
            fire = data_in_valid && data_in_ready;
            step();
            if (fire) k++;
            cyc++;
        end
        data_in_valid = 1'b0;
        total++;
        if (k != words.size()) begin
            bad++;
            $display("FAIL %s input_count: got=%0d want=%0d", tag, k, words.size());
        end

        total++;
        if (data_out_valid !== 1'b0 || data_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s compute_cycle: out_valid=%b in_ready=%b want 0 0", tag, data_out_valid, data_in_ready);
        end
        step();
        total++;
        if (data_out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s first_valid_latency: out_valid=%b want 1", tag, data_out_valid);
        end

        cnt = 0; cyc = 0;
        while (cnt < n && cyc < 3000) begin
            data_out_ready = out_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (start_in_send && cyc == 0) begin
                start = 1'b1; rows = 16'd1; cols = 16'd1; mode = 2'd0;
            end
            total++;
            if (data_out_valid !== 1'b1 || data_out !== expq[cnt]) begin
                bad++;
                $display("FAIL %s out_word[%0d]: valid=%b data=%h want valid=1 data=%h",
                         tag, cnt, data_out_valid, data_out, expq[cnt]);
            end
            fire = data_out_valid && data_out_ready;
            step();
            start = 1'b0;
            if (fire) cnt++;
            cyc++;
        end
        data_out_ready = 1'b0;
        total++;
        if (cnt != n) begin
            bad++;
            $display("FAIL %s output_count: got=%0d want=%0d", tag, cnt, n);
        end
        total++;
        if (data_out_valid !== 1'b0 || done !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL %s fin: out_valid=%b done=%b err=%b want 0 1 0", tag, data_out_valid, done, err);
        end
        step();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s back_to_idle: done=%b busy=%b want 0 0", tag, done, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        total++;
        if ({busy, done, err, data_in_ready, data_out_valid} !== 5'b0 || data_out !== '0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b err=%b in_ready=%b out_valid=%b data_out=%h want all 0",
                     busy, done, err, data_in_ready, data_out_valid, data_out);
        end
    endtask

    task automatic test_directed();
        fill(1'b0);
        run_job(4, 2'd0, 1'b0, 1'b0, 1'b0, "mode0_n4");
        fill(1'b1);
        run_job(3, 2'd2, 1'b0, 1'b0, 1'b0, "mode2_diag");
        run_job(3, 2'd1, 1'b0, 1'b0, 1'b0, "mode1_b789");
    endtask

    task automatic test_err(input logic [15:0] r, input logic [15:0] c, input logic [1:0] m, input string tag);
        bit saw_ready, saw_done;
        int done_at;
        rows = r; cols = c; mode = m; start = 1'b1;
        data_in_valid = 1'b1;
        step();
        start = 1'b0;
        saw_ready = 1'b0; saw_done = 1'b0; done_at = -1;
        for (int i = 0; i < 3; i++) begin
            if (data_in_ready) saw_ready = 1'b1;
            if (done && err && !saw_done) begin
                saw_done = 1'b1;
                done_at  = i;
            end
            step();
        end
        data_in_valid = 1'b0;
        total++;
        if (saw_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s in_ready_seen: got=%b want=0", tag, saw_ready);
        end
        total++;
        if (done_at != 1) begin
            bad++;
            $display("FAIL %s err_done_timing: done_cycle=%0d want=1", tag, done_at);
        end
        total++;
        if (busy !== 1'b0 || err !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s err_hold: busy=%b err=%b done=%b want 0 1 0", tag, busy, err, done);
        end
    endtask

    task automatic test_abort();
        int sent;
        bit saw_done;
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: busy=%b done=%b want 0 0", busy, done);
        end
        fill(1'b0);
        rows = 16'd4; cols = 16'd4; mode = 2'd1; start = 1'b1;
        step();
        start = 1'b0;
        feed(5, sent);
        total++;
        if (sent != 5) begin
            bad++;
            $display("FAIL abort_feed: sent=%0d want=5", sent);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || data_in_ready !== 1'b0 || data_out_valid !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL abort_state: busy=%b in_ready=%b out_valid=%b err=%b want 0 0 0 0",
                     busy, data_in_ready, data_out_valid, err);
        end
        saw_done = done;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done) saw_done = 1'b1;
        end
        total++;
        if (saw_done !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_done: done_seen=%b want 0", saw_done);
        end
        fill(1'b0);
        run_job(2, 2'd2, 1'b1, 1'b0, 1'b0, "after_abort_m2");
        run_job(2, 2'd1, 1'b0, 1'b1, 1'b0, "after_abort_m1");
    endtask

    task automatic test_start_in_send();
        fill(1'b0);
        run_job(4, 2'd1, 1'b0, 1'b1, 1'b1, "start_in_send");
    endtask

    task automatic test_reset_mid();
        int sent;
        fill(1'b0);
        rows = 16'd3; cols = 16'd3; mode = 2'd2; start = 1'b1;
        step();
        start = 1'b0;
        feed(4, sent);
        reset = 1'b1;
        data_in_valid = 1'b1;
        step();
        reset = 1'b0;
        data_in_valid = 1'b0;
        total++;
        if ({busy, done, err, data_in_ready, data_out_valid} !== 5'b0 || data_out !== '0) begin
            bad++;
            $display("FAIL reset_mid_recv: busy=%b done=%b err=%b in_ready=%b out_valid=%b data_out=%h want all 0",
                     busy, done, err, data_in_ready, data_out_valid, data_out);
        end
        fill(1'b0);
        run_job(3, 2'd2, 1'b1, 1'b1, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 8; j++) begin
            fill(1'b0);
            run_job(int'($urandom_range(1, 6)), 2'($urandom_range(0, 2)), 1'b1, 1'b1, 1'b0, "random_job");
        end
        fill(1'b0);
        run_job(NM, 2'd2, 1'b1, 1'b1, 1'b0, "max_order_m2");
        run_job(NM, 2'd1, 1'b0, 1'b1, 1'b0, "max_order_m1");
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        rows = '0; cols = '0; mode = '0;
        data_in = '0; data_in_valid = 1'b0; data_out_ready = 1'b0;
        test_reset();
        test_directed();
        test_err(16'd3, 16'd4, 2'd0, "err_rect");
        test_err(16'(NM + 1), 16'(NM + 1), 2'd0, "err_too_big");
        test_err(16'd2, 16'd2, 2'd3, "err_mode3");
        test_err(16'd0, 16'd0, 2'd1, "err_zero");
        test_abort();
        test_start_in_send();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
